// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types and default constants for the player motion block
package player_pkg;

   typedef logic [15:0] coord_t;

   typedef enum logic [1:0] {
      S_GROUND = 2'd0,
      S_RISE   = 2'd1,
      S_FALL   = 2'd2
   } state_t;

   localparam coord_t X_MAX_DEF    = 16'd640;
   localparam coord_t Y_GROUND_DEF = 16'd400;
   localparam coord_t GRAVITY_DEF  = 16'd1;
   localparam coord_t VY_MAX_DEF   = 16'd32;

   // Unsigned saturation used for take-off velocity
   function automatic coord_t sat_coord(coord_t v, coord_t lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/player_motion_if.sv
// rtl/player_motion_if.sv - control inputs and position outputs of the player motion block
interface player_motion_if;
   import player_pkg::*;

   logic   i_frame_tick;
   logic   i_run;
   coord_t i_run_speed;
   logic   i_jump;
   coord_t i_jump_height;
   coord_t o_x;
   coord_t o_y;
   state_t o_state;
   logic   o_airborne;
   logic   o_land;

   // master: the control source / renderer side
   modport master (
      output i_frame_tick, i_run, i_run_speed, i_jump, i_jump_height,
      input  o_x, o_y, o_state, o_airborne, o_land
   );

   // slave: the motion integrator
   modport slave (
      input  i_frame_tick, i_run, i_run_speed, i_jump, i_jump_height,
      output o_x, o_y, o_state, o_airborne, o_land
   );

endinterface

// File: rtl/player_x_accum.sv
// rtl/player_x_accum.sv - wrapping horizontal scroll accumulator, advances on run ticks
module player_x_accum
   import player_pkg::*;
#(
   parameter coord_t X_MAX = X_MAX_DEF
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_tick,
   input  logic   i_run,
   input  coord_t i_speed,
   output coord_t o_x
);

   coord_t      x_q, x_d;
   logic [16:0] sum;
   coord_t      x_wrap;

   // 17-bit sum so the wrap compare never overflows; a single subtract is enough
   // because speed is below X_MAX
   assign sum    = {1'b0, x_q} + {1'b0, i_speed};
   assign x_wrap = sum[15:0] - X_MAX;

   // next x: advance only on a tick with run asserted
   always_comb begin
      x_d = x_q;
      if (i_tick && i_run) begin
         if (sum >= {1'b0, X_MAX}) x_d = x_wrap;
         else                      x_d = sum[15:0];
      end
   end

   // x register
   always_ff @(posedge i_clk) begin
      if (i_rst) x_q <= '0;
      else       x_q <= x_d;
   end

   assign o_x = x_q;

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player position integrator; JUMP_BUFFER_EN buffers airborne jumps
module player_motion
   import player_pkg::*;
#(
   parameter coord_t X_MAX    = X_MAX_DEF,
   parameter coord_t Y_GROUND = Y_GROUND_DEF,
   parameter coord_t GRAVITY  = GRAVITY_DEF,
   parameter coord_t VY_MAX   = VY_MAX_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   player_motion_if.slave  bus
);

`ifdef JUMP_BUFFER_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   state_t state_q, state_d;
   coord_t y_q, y_d;
   coord_t vy_q, vy_d;
   logic   pending_q, pending_d;
   coord_t pend_v_q, pend_v_d;
   logic   land_q, land_d;
   logic   airborne_q, airborne_d;

   logic        jump_ok;
   coord_t      jump_v;
   logic [16:0] vy_inc;
   coord_t      vy_fall;
   logic [16:0] y_fall_sum;

   // A jump is accepted on the ground, or anywhere when buffering is built in
   assign jump_ok = bus.i_jump && (bus.i_jump_height != '0) &&
                    (BUF_EN || (state_q == S_GROUND));
   assign jump_v  = sat_coord(bus.i_jump_height, VY_MAX);

   // Falling velocity grows in 17 bits before saturating to VY_MAX
   assign vy_inc     = {1'b0, vy_q} + {1'b0, GRAVITY};
   assign vy_fall    = (vy_inc > {1'b0, VY_MAX}) ? VY_MAX : vy_inc[15:0];
   assign y_fall_sum = {1'b0, y_q} + {1'b0, vy_fall};

   // Vertical FSM next-state: jump capture first, so a same-cycle tick consumes it
   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      vy_d      = vy_q;
      pending_d = pending_q;
      pend_v_d  = pend_v_q;
      land_d    = 1'b0;

      if (jump_ok) begin
         pending_d = 1'b1;
         pend_v_d  = jump_v;
      end

      if (bus.i_frame_tick) begin
         case (state_q)
            S_GROUND: begin
               if (pending_d) begin
                  vy_d      = pend_v_d;
                  pending_d = 1'b0;
                  pend_v_d  = '0;
                  state_d   = S_RISE;
               end
            end
            S_RISE: begin
               y_d = (vy_q > y_q) ? '0 : (y_q - vy_q);
               if (vy_q <= GRAVITY) begin
                  vy_d    = '0;
                  state_d = S_FALL;
               end else begin
                  vy_d = vy_q - GRAVITY;
               end
            end
            S_FALL: begin
               if (y_fall_sum >= {1'b0, Y_GROUND}) begin
                  y_d     = Y_GROUND;
                  vy_d    = '0;
                  state_d = S_GROUND;
                  land_d  = 1'b1;
               end else begin
                  y_d  = y_fall_sum[15:0];
                  vy_d = vy_fall;
               end
            end
            default: begin
               state_d = S_GROUND;
               y_d     = Y_GROUND;
               vy_d    = '0;
            end
         endcase
      end

      airborne_d = (state_d != S_GROUND);
   end

   // Vertical state registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_GROUND;
         y_q        <= Y_GROUND;
         vy_q       <= '0;
         pending_q  <= 1'b0;
         pend_v_q   <= '0;
         land_q     <= 1'b0;
         airborne_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         vy_q       <= vy_d;
         pending_q  <= pending_d;
         pend_v_q   <= pend_v_d;
         land_q     <= land_d;
         airborne_q <= airborne_d;
      end
   end

   player_x_accum #(
      .X_MAX (X_MAX)
   ) u_x_accum (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_tick  (bus.i_frame_tick),
      .i_run   (bus.i_run),
      .i_speed (bus.i_run_speed),
      .o_x     (bus.o_x)
   );

   assign bus.o_y        = y_q;
   assign bus.o_state    = state_q;
   assign bus.o_airborne = airborne_q;
   assign bus.o_land     = land_q;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - scoreboard bench for player_motion against a frame-level physics model
module tb_player_motion;

   typedef struct {
      int tag;
      int x;
      int y;
      int st;
      int air;
      int land;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

`ifdef JUMP_BUFFER_EN
   localparam bit M_BUF = 1'b1;
`else
   localparam bit M_BUF = 1'b0;
`endif

   // Model state: plain frame physics
   int m_x, m_y, m_vy, m_st, m_pv;
   bit m_pend, m_land;

   player_motion_if bus();

   player_motion dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic void chk(string name, int act, int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, expv);
      end
   endfunction

   // Monitor: pops every expectation due at this edge and compares mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("x",        int'(bus.o_x),        e.x);
            chk("y",        int'(bus.o_y),        e.y);
            chk("state",    int'(bus.o_state),    e.st);
            chk("airborne", int'(bus.o_airborne), e.air);
            chk("land",     int'(bus.o_land),     e.land);
         end
      end
   end

   // One clock: drive inputs, advance the model, queue the expected outputs
   task automatic step(input bit r, input bit tick, input bit run, input int speed,
                       input bit jump, input int height);
      exp_t e;
      bit   nj;
      int   jv;
      rst               = r;
      bus.i_frame_tick  = tick;
      bus.i_run         = run;
      bus.i_run_speed   = 16'(speed);
      bus.i_jump        = jump;
      bus.i_jump_height = 16'(height);

      if (r) begin
         m_x = 0; m_y = 400; m_vy = 0; m_st = 0; m_pend = 0; m_pv = 0; m_land = 0;
      end else begin
         m_land = 0;
         nj = jump && (height != 0) && (M_BUF || m_st == 0);
         jv = (height > 32) ? 32 : height;
         if (nj) begin
            m_pend = 1;
            m_pv   = jv;
         end
         if (tick) begin
            if (run) m_x = (m_x + speed) % 640;
            if (m_st == 0) begin
               if (m_pend) begin
                  m_vy = m_pv; m_pend = 0; m_st = 1;
               end
            end else if (m_st == 1) begin
               m_y = (m_y - m_vy < 0) ? 0 : m_y - m_vy;
               if (m_vy <= 1) begin
                  m_vy = 0; m_st = 2;
               end else begin
                  m_vy = m_vy - 1;
               end
            end else begin
               m_vy = (m_vy + 1 > 32) ? 32 : m_vy + 1;
               if (m_y + m_vy >= 400) begin
                  m_y = 400; m_vy = 0; m_st = 0; m_land = 1;
               end else begin
                  m_y = m_y + m_vy;
               end
            end
         end
      end

      e.tag  = edge_cnt + 1;
      e.x    = m_x;
      e.y    = m_y;
      e.st   = m_st;
      e.air  = (m_st != 0) ? 1 : 0;
      e.land = m_land ? 1 : 0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick_idle();
      step(0, 1, 0, 0, 0, 0);
      idle();
   endtask

   initial begin
      // Reset held for two cycles
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      idle();

      // Full arc of a height-4 jump plus a couple of ground ticks
      step(0, 0, 0, 0, 1, 4);
      for (int i = 0; i < 11; i++) tick_idle();

      // Saturated take-off, then fly until landing (bounded)
      step(0, 0, 0, 0, 1, 100);
      for (int i = 0; i < 100 && (i == 0 || m_st != 0); i++) tick_idle();
      tick_idle();

      // Zero height is ignored, also when sampled on the tick
      step(0, 0, 0, 0, 1, 0);
      tick_idle();
      step(0, 1, 0, 0, 1, 0);
      idle();

      // Jump on the same cycle as a ground tick is consumed by it
      step(0, 1, 0, 0, 1, 3);
      for (int i = 0; i < 12; i++) tick_idle();

      // Wrap: reach 638, then +4 wraps to 2; run low holds x
      step(0, 1, 1, 319, 0, 0);
      step(0, 1, 1, 319, 0, 0);
      step(0, 1, 1, 4, 0, 0);
      step(0, 1, 0, 9, 0, 0);
      step(0, 1, 1, 639, 0, 0);
      idle();

      // Airborne jump request on the cycle of the third tick
      step(0, 0, 0, 0, 1, 4);
      tick_idle();
      tick_idle();
      step(0, 1, 0, 0, 1, 4);
      idle();
      for (int i = 0; i < 12; i++) tick_idle();

      // Reset mid-air at y=393 with a buffered request outstanding
      step(0, 0, 0, 0, 1, 4);
      tick_idle();
      tick_idle();
      tick_idle();
      step(0, 0, 0, 0, 1, 5);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick_idle();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         int h;
         h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 12));
         step(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 2) == 0),
              $urandom_range(0, 1),
              int'($urandom_range(0, 639)),
              ($urandom_range(0, 9) == 0),
              h);
      end

      idle();
      idle();
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
